// File: rtl/gpu_pkg.sv
// gpu_pkg: core state encodings and default core geometry shared by the core blocks
package gpu_pkg;

    localparam int DEF_THREADS = 4;
    localparam int DEF_PC_BITS = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } core_state_t;

endpackage

// File: rtl/pc_div_stack.sv
// pc_div_stack: LIFO of {mask, pc} entries holding deferred divergent paths
module pc_div_stack #(
    parameter int THREADS = 4,
    parameter int PC_BITS = 8,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [THREADS-1:0] i_mask,
    input  logic [PC_BITS-1:0] i_pc,
    output logic               o_full,
    output logic               o_empty,
    output logic [THREADS-1:0] o_top_mask,
    output logic [PC_BITS-1:0] o_top_pc
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [SP_W-1:0]    r_sp;
    logic [THREADS-1:0] r_mask [DEPTH];
    logic [PC_BITS-1:0] r_pc   [DEPTH];
    logic [IDX_W-1:0]   w_top;

    assign o_full     = r_sp == SP_W'(DEPTH);
    assign o_empty    = r_sp == '0;
    assign w_top      = o_empty ? '0 : IDX_W'(r_sp - 1'b1);
    assign o_top_mask = r_mask[w_top];
    assign o_top_pc   = r_pc[w_top];

    // push writes the next free slot; a push on a full stack is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mask[i] <= '0;
                r_pc[i]   <= '0;
            end
        end else if (i_push && !o_full) begin
            r_mask[IDX_W'(r_sp)] <= i_mask;
            r_pc[IDX_W'(r_sp)]   <= i_pc;
            r_sp                 <= r_sp + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_sp <= r_sp - 1'b1;
        end
    end

endmodule

// File: rtl/core_pc_scheduler.sv
// core_pc_scheduler: per-core FSM sequencing PC units, merging thread PCs and serialising divergence
module core_pc_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS     = DEF_THREADS,
    parameter int PC_BITS     = DEF_PC_BITS,
    parameter int STACK_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_start,
    input  logic [$clog2(THREADS):0]   i_thread_count,
    input  logic                       i_fetch_done,
    input  logic                       i_decoded_ret,
    input  logic [THREADS-1:0]         i_lsu_busy,
    input  logic [THREADS*PC_BITS-1:0] i_next_pc,
    output logic                       o_fetch_req,
    output logic [2:0]                 o_core_state,
    output logic [PC_BITS-1:0]         o_current_pc,
    output logic [THREADS-1:0]         o_active_mask,
    output logic                       o_done,
    output logic                       o_stack_err
);

    core_state_t        r_state, w_state_n;
    logic [PC_BITS-1:0] r_pc, w_pc_n, w_lead_pc, w_div_pc, w_top_pc;
    logic [THREADS-1:0] r_mask, w_mask_n, w_match, w_div, w_tc_mask, w_top_mask;
    logic               r_fetch, r_done, r_err, w_err_n, w_push, w_pop, w_full, w_empty;

    pc_div_stack #(
        .THREADS (THREADS),
        .PC_BITS (PC_BITS),
        .DEPTH   (STACK_DEPTH)
    ) u_stack (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_pop),
        .i_mask     (w_div),
        .i_pc       (w_div_pc),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_top_mask (w_top_mask),
        .o_top_pc   (w_top_pc)
    );

    // leader PC, threads agreeing with it, the diverging remainder and its leader PC
    always_comb begin
        w_lead_pc = '0;
        w_div_pc  = '0;
        w_match   = '0;
        w_tc_mask = '0;
        for (int t = THREADS - 1; t >= 0; t--) begin
            if (r_mask[t]) w_lead_pc = i_next_pc[t*PC_BITS +: PC_BITS];
        end
        for (int t = 0; t < THREADS; t++) begin
            w_match[t]   = r_mask[t] && (i_next_pc[t*PC_BITS +: PC_BITS] == w_lead_pc);
            w_tc_mask[t] = t < int'(i_thread_count);
        end
        w_div = r_mask & ~w_match;
        for (int t = THREADS - 1; t >= 0; t--) begin
            if (w_div[t]) w_div_pc = i_next_pc[t*PC_BITS +: PC_BITS];
        end
    end

    // next-state, next PC/mask and stack control
    always_comb begin
        w_state_n = r_state;
        w_pc_n    = r_pc;
        w_mask_n  = r_mask;
        w_err_n   = r_err;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        case (r_state)
            S_IDLE: if (i_start) begin
                w_state_n = S_FETCH;
                w_pc_n    = '0;
                w_mask_n  = w_tc_mask;
            end
            S_FETCH:   w_state_n = i_fetch_done ? S_DECODE : S_FETCH;
            S_DECODE:  w_state_n = S_REQUEST;
            S_REQUEST: w_state_n = S_WAIT;
            S_WAIT:    w_state_n = (i_lsu_busy & r_mask) == '0 ? S_EXECUTE : S_WAIT;
            S_EXECUTE: w_state_n = S_UPDATE;
            S_UPDATE: begin
                w_state_n = S_FETCH;
                if (i_decoded_ret && w_empty) begin
                    w_state_n = S_DONE;
                    w_mask_n  = '0;
                end else if (i_decoded_ret) begin
                    w_pop    = 1'b1;
                    w_mask_n = w_top_mask;
                    w_pc_n   = w_top_pc;
                end else begin
                    w_pc_n = w_lead_pc;
                    if (w_div != '0) begin
                        w_push   = 1'b1;
                        w_mask_n = w_match;
                        w_err_n  = r_err | w_full;
                    end
                end
            end
            default: ;
        endcase
    end

    // state and output registers; fetch_req and done follow the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_mask  <= '0;
            r_fetch <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_pc    <= w_pc_n;
            r_mask  <= w_mask_n;
            r_fetch <= w_state_n == S_FETCH;
            r_done  <= w_state_n == S_DONE;
            r_err   <= w_err_n;
        end
    end

    assign o_core_state  = r_state;
    assign o_current_pc  = r_pc;
    assign o_active_mask = r_mask;
    assign o_fetch_req   = r_fetch;
    assign o_done        = r_done;
    assign o_stack_err   = r_err;

endmodule

// File: tb/tb_core_pc_scheduler.sv
// tb_core_pc_scheduler: directed scenarios with a scoreboard of expected FETCH/DONE snapshots
module tb_core_pc_scheduler;
    import gpu_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, i_start = 1'b0, i_fetch_done = 1'b0;
    logic [2:0]  i_thread_count = '0;
    logic [3:0]  i_lsu_busy = '0;
    logic [31:0] i_next_pc;
    logic        i_decoded_ret;
    logic        o_fetch_req, o_done, o_stack_err;
    logic [2:0]  o_core_state;
    logic [7:0]  o_current_pc;
    logic [3:0]  o_active_mask;

    logic [31:0] np_tab [256];
    bit          ret_tab [256];
    logic [16:0] exp_q [$];
    logic [2:0]  prev_state = '0;
    int          passed = 0, total = 0, fetch_delay = 1, fcnt = 0;

    core_pc_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .i_start        (i_start),
        .i_thread_count (i_thread_count),
        .i_fetch_done   (i_fetch_done),
        .i_decoded_ret  (i_decoded_ret),
        .i_lsu_busy     (i_lsu_busy),
        .i_next_pc      (i_next_pc),
        .o_fetch_req    (o_fetch_req),
        .o_core_state   (o_core_state),
        .o_current_pc   (o_current_pc),
        .o_active_mask  (o_active_mask),
        .o_done         (o_done),
        .o_stack_err    (o_stack_err)
    );

    assign i_next_pc     = np_tab[o_current_pc];
    assign i_decoded_ret = ret_tab[o_current_pc];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [16:0] ex(input logic [2:0] s, input logic [7:0] pc,
                                       input logic [3:0] m, input logic e, input logic d);
        return {s, pc, m, e, d};
    endfunction

    function automatic logic [16:0] snap();
        return {o_core_state, o_current_pc, o_active_mask, o_stack_err, o_done};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            np_tab[i]  = '0;
            ret_tab[i] = 1'b0;
        end
    endtask

    task automatic pulse_start(input logic [2:0] tc);
        i_thread_count = tc;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget, input string name);
        int n = 0;
        while (o_core_state !== s && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (o_core_state !== s) chk(name, {29'd0, o_core_state}, {29'd0, s});
    endtask

    // fetcher model: fetch_done rises fetch_delay cycles into a request
    initial forever begin
        @(posedge clk);
        #1;
        if (o_fetch_req) begin
            fcnt = fcnt + 1;
            i_fetch_done = fcnt >= fetch_delay;
        end else begin
            fcnt = 0;
            i_fetch_done = 1'b0;
        end
    end

    // monitor: every entry into FETCH or DONE is checked against the next expected snapshot
    initial forever begin
        @(negedge clk);
        if (!reset && ((o_core_state == S_FETCH && prev_state != S_FETCH) ||
                       (o_core_state == S_DONE && prev_state != S_DONE))) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL scoreboard: got snapshot %h expected none", snap());
            end else chk("scoreboard", {15'd0, snap()}, {15'd0, exp_q.pop_front()});
        end
        prev_state = o_core_state;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        clear_prog();
        do_reset();
        chk("rst_state", {29'd0, o_core_state}, 32'd0);
        chk("rst_pc", {24'd0, o_current_pc}, 32'd0);
        chk("rst_mask", {28'd0, o_active_mask}, 32'd0);
        chk("rst_fetch_req", {31'd0, o_fetch_req}, 32'd0);
        chk("rst_done", {31'd0, o_done}, 32'd0);
        chk("rst_stack_err", {31'd0, o_stack_err}, 32'd0);

        // straight-line block, 3 threads, RET at pc 3
        clear_prog();
        for (int i = 0; i < 4; i++) np_tab[i] = {4{8'(i + 1)}};
        ret_tab[3] = 1'b1;
        fetch_delay = 2;
        for (int i = 0; i < 4; i++) exp_q.push_back(ex(S_FETCH, 8'(i), 4'b0111, 1'b0, 1'b0));
        exp_q.push_back(ex(S_DONE, 8'd3, 4'b0000, 1'b0, 1'b1));
        pulse_start(3'd3);
        n = 0;
        while (o_core_state == S_FETCH && n < 20) begin @(negedge clk); n++; end
        while (o_core_state != S_FETCH && n < 20) begin @(negedge clk); n++; end
        chk("fetch_to_fetch_latency", n, 32'd7);
        wait_state(S_DONE, 200, "run_a_done_timeout");
        chk("run_a_done", {31'd0, o_done}, 32'd1);
        pulse_start(3'd4);
        chk("start_in_done_state", {29'd0, o_core_state}, {29'd0, S_DONE});
        chk("start_in_done_mask", {28'd0, o_active_mask}, 32'd0);

        // divergence {9,9,4,4} then two RETs
        do_reset();
        clear_prog();
        np_tab[0] = {8'd9, 8'd9, 8'd4, 8'd4};
        ret_tab[4] = 1'b1;
        ret_tab[9] = 1'b1;
        fetch_delay = 1;
        exp_q.push_back(ex(S_FETCH, 8'd0, 4'b1111, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd4, 4'b0011, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd9, 4'b1100, 1'b0, 1'b0));
        exp_q.push_back(ex(S_DONE, 8'd9, 4'b0000, 1'b0, 1'b1));
        pulse_start(3'd4);
        wait_state(S_DONE, 200, "run_b_done_timeout");

        // three nested divergences overflow a two-entry stack
        do_reset();
        clear_prog();
        np_tab[0] = {8'd30, 8'd1, 8'd1, 8'd1};
        np_tab[1] = {8'd99, 8'd31, 8'd2, 8'd2};
        np_tab[2] = {8'd99, 8'd99, 8'd32, 8'd3};
        ret_tab[3]  = 1'b1;
        ret_tab[31] = 1'b1;
        ret_tab[30] = 1'b1;
        exp_q.push_back(ex(S_FETCH, 8'd0,  4'b1111, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd1,  4'b0111, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd2,  4'b0011, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd3,  4'b0001, 1'b1, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd31, 4'b0100, 1'b1, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd30, 4'b1000, 1'b1, 1'b0));
        exp_q.push_back(ex(S_DONE,  8'd30, 4'b0000, 1'b1, 1'b1));
        pulse_start(3'd4);
        wait_state(S_DONE, 300, "run_c_done_timeout");

        // WAIT stall on an active thread, then inactive busy bits ignored
        do_reset();
        clear_prog();
        np_tab[0] = {4{8'd1}};
        ret_tab[1] = 1'b1;
        i_lsu_busy = 4'b0010;
        exp_q.push_back(ex(S_FETCH, 8'd0, 4'b0011, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd1, 4'b0011, 1'b0, 1'b0));
        exp_q.push_back(ex(S_DONE,  8'd1, 4'b0000, 1'b0, 1'b1));
        pulse_start(3'd2);
        wait_state(S_WAIT, 50, "run_d_wait_timeout");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wait_stall", {29'd0, o_core_state}, {29'd0, S_WAIT});
        end
        i_lsu_busy = 4'b1000;
        @(negedge clk);
        chk("wait_exit", {29'd0, o_core_state}, {29'd0, S_EXECUTE});
        pulse_start(3'd4);
        chk("start_in_execute_state", {29'd0, o_core_state}, {29'd0, S_UPDATE});
        chk("start_in_execute_mask", {28'd0, o_active_mask}, 32'd3);
        wait_state(S_WAIT, 50, "run_d_wait2_timeout");
        @(negedge clk);
        chk("inactive_busy_no_stall", {29'd0, o_core_state}, {29'd0, S_EXECUTE});
        wait_state(S_DONE, 100, "run_d_done_timeout");

        // reset while stalled in WAIT at a nonzero pc
        do_reset();
        clear_prog();
        i_lsu_busy = 4'b0000;
        np_tab[0] = {4{8'd5}};
        exp_q.push_back(ex(S_FETCH, 8'd0, 4'b1111, 1'b0, 1'b0));
        exp_q.push_back(ex(S_FETCH, 8'd5, 4'b1111, 1'b0, 1'b0));
        pulse_start(3'd4);
        wait_state(S_WAIT, 50, "run_e_wait_timeout");
        @(negedge clk);
        i_lsu_busy = 4'b1111;
        wait_state(S_WAIT, 50, "run_e_wait2_timeout");
        repeat (2) @(negedge clk);
        chk("stalled_pc", {24'd0, o_current_pc}, 32'd5);
        reset = 1'b1;
        @(negedge clk);
        chk("midwait_rst_state", {29'd0, o_core_state}, 32'd0);
        chk("midwait_rst_pc", {24'd0, o_current_pc}, 32'd0);
        chk("midwait_rst_mask", {28'd0, o_active_mask}, 32'd0);
        chk("midwait_rst_fetch_req", {31'd0, o_fetch_req}, 32'd0);
        reset = 1'b0;
        i_lsu_busy = 4'b0000;
        @(negedge clk);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
